// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM duty sequencer: mode codes, writer states, widths.
package pwm_pkg;
  localparam int NUM_CH = 3;
  localparam int DUTY_W = 8;

  localparam logic [1:0] MODE_MAN  = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd2;

  typedef enum logic [2:0] {WR_IDLE, WR_W0, WR_W1, WR_W2, WR_WS} wr_state_e;
endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Duty-write port toward the PWM block: one-cycle strobe plus channel and value.
interface pwm_duty_sequencer_if;
  import pwm_pkg::*;
  logic              wr;
  logic [1:0]        wr_ch;
  logic [DUTY_W-1:0] wr_val;

  modport master (output wr, wr_ch, wr_val);
  modport slave  (input  wr, wr_ch, wr_val);
endinterface

// File: rtl/pwm_duty_sequencer_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-sample counter, one-cycle press pulse.
module btn_debounce #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Any sample agreeing with the current level restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q >= DB_CYCLES - 16'd1) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer: debounced buttons drive MAN/RAMP/OFF modes and a serialised duty writer.
// Optional RAMP_PHASE_EN: entering RAMP presets a 0/85/170 phase spread and writes it.
module pwm_duty_sequencer import pwm_pkg::*; #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter logic [7:0]  STEP      = 8'd16,
  parameter logic [7:0]  RAMP_DIV  = 8'd4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_mode,
  input  logic                        btn_sel,
  input  logic                        btn_step,
  input  logic                        period_tick,
  pwm_duty_sequencer_if.master        wr_if,
  output logic [1:0]                  mode,
  output logic [1:0]                  sel,
  output logic                        busy
);
  logic [2:0] press;  // {step, sel, mode}

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   ({btn_step, btn_sel, btn_mode}),
    .press (press)
  );

  logic [1:0]                   mode_q, mode_d, sel_q, sel_d, one_ch_q, one_ch_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] sh_q, sh_d;
  logic [NUM_CH-1:0]            dn_q, dn_d;  // 1 = channel ramping down
  logic [7:0]                   div_q, div_d;
  logic                         pend_all_q, pend_all_d, pend_one_q, pend_one_d;
  wr_state_e                    st_q, st_d;
  logic                         req_all, req_one;
  logic [8:0]                   sum;
  logic [1:0]                   wch;

  always_comb begin
    mode_d  = mode_q;
    sel_d   = sel_q;
    sh_d    = sh_q;
    dn_d    = dn_q;
    div_d   = div_q;
    req_all = 1'b0;
    req_one = 1'b0;
    sum     = '0;
    if (press[0]) begin
      case (mode_q)
        MODE_MAN: begin
          mode_d = MODE_RAMP;
`ifdef RAMP_PHASE_EN
          sh_d    = {8'd170, 8'd85, 8'd0};
          dn_d    = '0;
          req_all = 1'b1;
`endif
        end
        MODE_RAMP: begin
          mode_d  = MODE_OFF;
          sh_d    = '0;
          req_all = 1'b1;
        end
        default: mode_d = MODE_MAN;
      endcase
    end else if (mode_q == MODE_MAN) begin
      if (press[1]) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      if (press[2]) begin
        sum           = {1'b0, sh_q[sel_q]} + {1'b0, STEP};
        sh_d[sel_q]   = sum[8] ? '0 : sum[7:0];
        req_one       = 1'b1;
      end
    end else if (mode_q == MODE_RAMP && period_tick) begin
      div_d = div_q + 8'd1;
      if (div_d >= RAMP_DIV) begin
        div_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!dn_q[i]) begin
            sum = {1'b0, sh_q[i]} + {1'b0, STEP};
            if (sum >= 9'd255) begin
              sh_d[i] = 8'd255;
              dn_d[i] = 1'b1;
            end else begin
              sh_d[i] = sum[7:0];
            end
          end else if (sh_q[i] <= STEP) begin
            sh_d[i] = '0;
            dn_d[i] = 1'b0;
          end else begin
            sh_d[i] = sh_q[i] - STEP;
          end
        end
        req_all = 1'b1;
      end
    end
  end

  always_comb begin
    st_d       = st_q;
    pend_all_d = pend_all_q;
    pend_one_d = pend_one_q;
    one_ch_d   = req_one ? sel_q : one_ch_q;
    case (st_q)
      WR_IDLE: begin
        if (req_all || pend_all_q) begin
          st_d       = WR_W0;
          pend_all_d = 1'b0;
          pend_one_d = 1'b0;
        end else if (req_one || pend_one_q) begin
          st_d       = WR_WS;
          pend_one_d = 1'b0;
        end
      end
      WR_W0:   st_d = WR_W1;
      WR_W1:   st_d = WR_W2;
      default: st_d = WR_IDLE;
    endcase
    // While a sequence is in flight, new requests wait in one-deep flags.
    if (st_q != WR_IDLE) begin
      if (req_all) begin
        pend_all_d = 1'b1;
        pend_one_d = 1'b0;
      end else if (req_one && !pend_all_q) begin
        pend_one_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_if.wr = 1'b1;
    wch      = 2'd0;
    case (st_q)
      WR_W0:   wch = 2'd0;
      WR_W1:   wch = 2'd1;
      WR_W2:   wch = 2'd2;
      WR_WS:   wch = one_ch_q;
      default: wr_if.wr = 1'b0;
    endcase
    wr_if.wr_ch  = wch;
    wr_if.wr_val = wr_if.wr ? sh_q[wch] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_MAN;
      sel_q      <= '0;
      one_ch_q   <= '0;
      sh_q       <= '0;
      dn_q       <= '0;
      div_q      <= '0;
      pend_all_q <= 1'b0;
      pend_one_q <= 1'b0;
      st_q       <= WR_IDLE;
    end else begin
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      one_ch_q   <= one_ch_d;
      sh_q       <= sh_d;
      dn_q       <= dn_d;
      div_q      <= div_d;
      pend_all_q <= pend_all_d;
      pend_one_q <= pend_one_d;
      st_q       <= st_d;
    end
  end

  assign mode = mode_q;
  assign sel  = sel_q;
  assign busy = (st_q != WR_IDLE);
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: a mode/duty model queues expected writes, a monitor pops them.
module tb_pwm_duty_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_sel = 1'b0, btn_step = 1'b0, period_tick = 1'b0;
  logic [1:0] mode, sel;
  logic       busy;

  pwm_duty_sequencer_if wif();

  pwm_duty_sequencer #(.DB_CYCLES(16'd4), .STEP(8'd16), .RAMP_DIV(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_step(btn_step),
    .period_tick(period_tick), .wr_if(wif), .mode(mode), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; int val; int alt; } exp_t;
  exp_t sb[$];
  int tot = 0, bad = 0, nwr = 0, last_wr_cyc = 0, tap_cyc = 0, tick_cyc = 0;
  int m_sh[3], m_dn[3], m_mode, m_sel, m_div;

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wif.wr) begin
      nwr++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        tot++; bad++;
        $display("FAIL unexpected_wr: got ch=%0d val=%0d want no write", wif.wr_ch, wif.wr_val);
      end else begin
        e = sb.pop_front();
        chk("wr_ch", int'(wif.wr_ch), e.ch);
        tot++;
        if (int'(wif.wr_val) != e.val && int'(wif.wr_val) != e.alt) begin
          bad++;
          $display("FAIL wr_val ch%0d: got %0d want %0d (or %0d)", e.ch, wif.wr_val, e.val, e.alt);
        end
      end
    end
  end

  task automatic push(input int ch, input int val, input int alt);
    exp_t e;
    e.ch = ch; e.val = val; e.alt = alt;
    sb.push_back(e);
  endtask

  task automatic push_all();
    for (int i = 0; i < 3; i++) push(i, m_sh[i], m_sh[i]);
  endtask

  task automatic m_reset();
    m_sh = '{0, 0, 0}; m_dn = '{0, 0, 0};
    m_mode = 0; m_sel = 0; m_div = 0;
    sb.delete();
  endtask

  // Triangle step: climb by 16 up to a 255 ceiling, fall by 16 to a 0 floor, turn at either end.
  task automatic m_ramp();
    int v;
    for (int i = 0; i < 3; i++) begin
      if (m_dn[i] == 0) begin
        v = m_sh[i] + 16;
        if (v >= 255) begin v = 255; m_dn[i] = 1; end
      end else begin
        v = m_sh[i] - 16;
        if (v <= 0) begin v = 0; m_dn[i] = 0; end
      end
      m_sh[i] = v;
    end
  endtask

  task automatic m_mode_press();
    case (m_mode)
      0: begin
        m_mode = 1;
`ifdef RAMP_PHASE_EN
        m_sh = '{0, 85, 170}; m_dn = '{0, 0, 0};
        push_all();
`endif
      end
      1: begin m_mode = 2; m_sh = '{0, 0, 0}; push_all(); end
      default: m_mode = 0;
    endcase
  endtask

  task automatic m_tick();
    if (m_mode == 1) begin
      m_div++;
      if (m_div == 2) begin m_div = 0; m_ramp(); push_all(); end
    end
  endtask

  task automatic tap(input logic [2:0] m);
    int h = 7 + $urandom_range(0, 3);
    @(negedge clk);
    {btn_step, btn_sel, btn_mode} = m;
    tap_cyc = cyc;
    repeat (h) @(negedge clk);
    {btn_step, btn_sel, btn_mode} = 3'b000;
    repeat (h) @(negedge clk);
  endtask

  task automatic do_step();
    int v;
    if (m_mode == 0) begin
      v = m_sh[m_sel] + 16;
      if (v > 255) v = 0;
      m_sh[m_sel] = v;
      push(m_sel, v, v);
    end
    tap(3'b100);
  endtask

  task automatic do_sel();
    if (m_mode == 0) m_sel = (m_sel + 1) % 3;
    tap(3'b010);
  endtask

  task automatic do_mode();
    m_mode_press();
    tap(3'b001);
  endtask

  task automatic pulse();
    @(negedge clk); period_tick = 1'b1; tick_cyc = cyc;
    @(negedge clk); period_tick = 1'b0;
  endtask

  task automatic tick();
    m_tick();
    pulse();
    repeat ($urandom_range(4, 8)) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({nm, "_pending"}, sb.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_btn, lat_tick, d, n, w0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_wr", int'(wif.wr), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Short glitch on step must not survive the debouncer.
    w0 = nwr;
    btn_step = 1'b1; repeat (3) @(negedge clk); btn_step = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_no_wr", nwr, w0);

    // 17 steps on channel 0: 16..240 then wrap to 0.
    do_step();
    lat_btn = last_wr_cyc - tap_cyc;
    repeat (16) do_step();
    drain("man_step");
    chk("man_step_count", nwr - w0, 17);

    do_sel(); do_sel();
    chk("sel_2", int'(sel), 2);
    do_step();
    do_sel();
    chk("sel_wrap", int'(sel), 0);
    do_step();
    drain("sel_step");

    repeat (10) if ($urandom_range(0, 1) != 0) do_sel(); else do_step();
    drain("man_rand");
    chk("man_rand_sel", int'(sel), m_sel);

    do_mode();
    chk("mode_ramp", int'(mode), 1);
    drain("ramp_entry");
    tick(); tick();
    lat_tick = last_wr_cyc - tick_cyc - 2;
    tick(); tick();
    drain("ramp");

    // Asynchronous reset landing in the middle of a burst.
    tick();
    m_tick();
    pulse();
    n = 0;
    while (!wif.wr && n < 20) begin @(negedge clk); n++; end
    chk("burst_seen", int'(wif.wr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", int'(wif.wr), 0);
    chk("arst_ch", int'(wif.wr_ch), 0);
    chk("arst_val", int'(wif.wr_val), 0);
    chk("arst_mode", int'(mode), 0);
    chk("arst_sel", int'(sel), 0);
    chk("arst_busy", int'(busy), 0);
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Ramp clamp at 255 with direction reversal; ticks in MAN must not advance the divider.
    repeat (15) do_step();
    drain("preload");
    repeat (3) tick();
    chk("man_tick_no_wr", sb.size(), 0);
    do_mode();
    repeat (4) tick();
    drain("clamp");

    // Mode press timed to take effect during W1 of a ramp burst.
    tick();
    d = lat_btn - lat_tick - 1;
    if (d < 0) d = 0;
    m_div = 0;
    m_ramp();
    push(0, m_sh[0], m_sh[0]);
    push(1, m_sh[1], 0);
    push(2, m_sh[2], 0);
    m_mode = 2;
    m_sh = '{0, 0, 0};
    push_all();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      btn_mode    = (i < 10);
      period_tick = (i == d);
    end
    drain("off_collide");
    chk("mode_off", int'(mode), 2);

    do_mode();
    chk("mode_man", int'(mode), 0);
    // Mode and step together: only the mode change happens.
    m_mode_press();
    tap(3'b101);
    drain("simul");
    chk("simul_mode", int'(mode), 1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
